bus_trace_mon: RTL and testbench

- Parametrised CPU bus trace monitor. It samples 6502-style bus cycles (address, data, R_W_n, sync) into a show-ahead trace FIFO and keeps saturating activity counters.
- Supports free-running wrap capture and address-triggered post-trigger capture, with an address window filter.
- Sits beside cpu_top/mem on the bus. Testbenches read it out through a valid/ready port in place of full-memory dumps.

---
 rtl/bus_trace_mon.sv | 180 ++++++++++++++++++
 tb/tb_bus_trace_mon.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_mon.sv
// Bus trace monitor for a 6502-style bus. It captures window-qualified bus cycles into a
// show-ahead FIFO, in free-running wrap mode or address-triggered mode, and keeps activity counters.
module bus_trace_mon #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int ENTRY_W   = ADDR_WIDTH + DATA_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bus_valid,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_data,
    input  logic                  bus_r_w_n,
    input  logic                  bus_sync,
    input  logic [ADDR_WIDTH-1:0] win_lo,
    input  logic [ADDR_WIDTH-1:0] win_hi,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] trig_addr,
    input  logic [PTR_W:0]        post_count,
    input  logic                  arm,
    input  logic                  stop,
    output logic [1:0]            state,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ENTRY_W-1:0]    rd_entry,
    output logic [PTR_W:0]        fill,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [PTR_W:0]     ONE_P  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]     FULL_P = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]   STEP_P = PTR_W'(1);

    state_t                 state_r, state_next_s;
    logic                   mode_r;
    logic [PTR_W:0]         remaining_r, rem_next_s;
    logic [PTR_W-1:0]       head_r, tail_r;
    logic [PTR_W:0]         fill_r;
    logic                   overflow_r;
    logic [CNT_WIDTH-1:0]   rd_cnt_r, wr_cnt_r, fetch_cnt_r;
    logic [ENTRY_W-1:0]     mem_r [DEPTH];

    logic qual_s, active_s, count_s, push_s, pop_s, full_s;
    logic wr_en_s, head_adv_s, ovf_set_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign qual_s   = bus_valid && (bus_addr >= win_lo) && (bus_addr <= win_hi);
    assign active_s = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
    assign count_s  = qual_s && active_s && !arm && !stop;
    assign full_s   = (fill_r == FULL_P);
    assign pop_s    = (fill_r != '0) && rd_ready;

    // In wrap mode a full FIFO makes room by dropping its oldest entry; triggered mode keeps old data.
    assign wr_en_s    = push_s && (!full_s || pop_s || !mode_r);
    assign head_adv_s = pop_s || (push_s && full_s && !mode_r);
    assign ovf_set_s  = push_s && full_s && !pop_s;

    // Next-state, trigger and post-trigger countdown decisions; arm beats stop beats capture.
    always_comb begin
        state_next_s = state_r;
        rem_next_s   = remaining_r;
        push_s       = 1'b0;
        if (arm) begin
            state_next_s = mode ? ST_ARMED : ST_CAPTURE;
            rem_next_s   = '0;
        end else if (stop && active_s) begin
            state_next_s = ST_DONE;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (qual_s && (bus_addr == trig_addr)) begin
                        push_s = 1'b1;
                        if (post_count <= ONE_P) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_CAPTURE;
                            rem_next_s   = post_count - ONE_P;
                        end
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (qual_s) begin
                        push_s = 1'b1;
                        if (mode_r) begin
                            rem_next_s   = remaining_r - ONE_P;
                            state_next_s = (remaining_r == ONE_P) ? ST_DONE : ST_CAPTURE;
                        end else begin
                            state_next_s = ST_CAPTURE;
                        end
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end
                default: state_next_s = state_r;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO pointers, fill, overflow, counters and latched capture mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r      <= 1'b0;
            remaining_r <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            fill_r      <= '0;
            overflow_r  <= 1'b0;
            rd_cnt_r    <= '0;
            wr_cnt_r    <= '0;
            fetch_cnt_r <= '0;
        end else if (arm) begin
            mode_r      <= mode;
            remaining_r <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            fill_r      <= '0;
            overflow_r  <= 1'b0;
            rd_cnt_r    <= '0;
            wr_cnt_r    <= '0;
            fetch_cnt_r <= '0;
        end else begin
            remaining_r <= rem_next_s;
            if (wr_en_s) tail_r <= tail_r + STEP_P;
            if (head_adv_s) head_r <= head_r + STEP_P;
            if (wr_en_s && !head_adv_s) begin
                fill_r <= fill_r + ONE_P;
            end else if (!wr_en_s && head_adv_s) begin
                fill_r <= fill_r - ONE_P;
            end
            if (ovf_set_s) overflow_r <= 1'b1;
            if (count_s && bus_r_w_n) rd_cnt_r <= sat_inc(rd_cnt_r);
            if (count_s && !bus_r_w_n) wr_cnt_r <= sat_inc(wr_cnt_r);
            if (count_s && bus_r_w_n && bus_sync) fetch_cnt_r <= sat_inc(fetch_cnt_r);
        end
    end

    // Trace storage; stale contents are never visible because the read port is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[tail_r] <= {bus_sync, bus_r_w_n, bus_addr, bus_data};
        end
    end

    assign state     = state_r;
    assign rd_valid  = (fill_r != '0);
    assign rd_entry  = rd_valid ? mem_r[head_r] : '0;
    assign fill      = fill_r;
    assign overflow  = overflow_r;
    assign rd_cnt    = rd_cnt_r;
    assign wr_cnt    = wr_cnt_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_bus_trace_mon.sv
// Directed bench for bus_trace_mon: stimulus queues expected trace entries and a negedge
// monitor compares them against every popped head entry.
module tb_bus_trace_mon;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int EW = AW + DW + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          bus_valid = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic [DW-1:0] bus_data = '0;
    logic          bus_r_w_n = 1'b0;
    logic          bus_sync = 1'b0;
    logic [AW-1:0] win_lo = 16'h0000;
    logic [AW-1:0] win_hi = 16'hFFFF;
    logic          mode = 1'b0;
    logic [AW-1:0] trig_addr = '0;
    logic [PW:0]   post_count = '0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    state;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [EW-1:0] rd_entry;
    logic [PW:0]   fill;
    logic          overflow;
    logic [15:0]   rd_cnt, wr_cnt, fetch_cnt;

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q [$];

    bus_trace_mon dut (
        .clk(clk), .reset_n(reset_n), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_r_w_n(bus_r_w_n), .bus_sync(bus_sync),
        .win_lo(win_lo), .win_hi(win_hi), .mode(mode), .trig_addr(trig_addr),
        .post_count(post_count), .arm(arm), .stop(stop), .state(state),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_entry(rd_entry), .fill(fill),
        .overflow(overflow), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each negedge with valid&ready is exactly one pop at the next edge.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got 0x%0h, wanted no entry", rd_entry);
            end else begin
                e = exp_q.pop_front();
                check("sb_entry", 32'(rd_entry), 32'(e));
            end
        end
    end

    function automatic logic [EW-1:0] ent(input logic sy, input logic rw,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {sy, rw, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rw, input logic sy);
        bus_valid = 1'b1;
        bus_addr  = a;
        bus_data  = d;
        bus_r_w_n = rw;
        bus_sync  = sy;
        tick();
        bus_valid = 1'b0;
    endtask

    task automatic do_arm(input logic m);
        rd_ready = 1'b0;
        mode = m;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (rd_valid && n < 64) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, wanted finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then bus activity while idle.
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) bus(16'h0010 + 16'(i), 8'(i), 1'(i % 2), 1'b1);
        check("idle_state", 32'(state), 32'd0);
        check("idle_fill", 32'(fill), 32'd0);
        check("idle_valid", 32'(rd_valid), 32'd0);
        check("idle_entry", 32'(rd_entry), 32'd0);
        check("idle_cnts", 32'(rd_cnt) + 32'(wr_cnt) + 32'(fetch_cnt), 32'd0);

        // Wrap mode overflow: 20 writes into 16 entries.
        do_arm(1'b0);
        check("wrap_state", 32'(state), 32'd2);
        for (int i = 0; i < 20; i++) bus(16'h0200 + 16'(i), 8'(i), 1'b0, 1'b0);
        check("wrap_fill", 32'(fill), 32'd16);
        check("wrap_ovf", 32'(overflow), 32'd1);
        check("wrap_wr_cnt", 32'(wr_cnt), 32'd20);
        check("wrap_rd_cnt", 32'(rd_cnt), 32'd0);
        for (int i = 4; i < 20; i++) exp_q.push_back(ent(1'b0, 1'b0, 16'h0200 + 16'(i), 8'(i)));
        drain();

        // Triggered capture, post_count=3.
        trig_addr = 16'h8000;
        post_count = 5'd3;
        do_arm(1'b1);
        check("trig_armed", 32'(state), 32'd1);
        check("trig_ovf_clr", 32'(overflow), 32'd0);
        bus(16'h7FFE, 8'hA0, 1'b1, 1'b0);
        bus(16'h7FFF, 8'hA1, 1'b1, 1'b0);
        check("trig_pre_fill", 32'(fill), 32'd0);
        bus(16'h8000, 8'hA2, 1'b1, 1'b1);
        check("trig_hit_state", 32'(state), 32'd2);
        bus(16'h8001, 8'hA3, 1'b1, 1'b0);
        bus(16'h8002, 8'hA4, 1'b1, 1'b0);
        check("trig_done", 32'(state), 32'd3);
        bus(16'h8003, 8'hA5, 1'b1, 1'b0);
        check("trig_fill", 32'(fill), 32'd3);
        check("trig_rd_cnt", 32'(rd_cnt), 32'd5);
        check("trig_fetch", 32'(fetch_cnt), 32'd1);
        exp_q.push_back(ent(1'b1, 1'b1, 16'h8000, 8'hA2));
        exp_q.push_back(ent(1'b0, 1'b1, 16'h8001, 8'hA3));
        exp_q.push_back(ent(1'b0, 1'b1, 16'h8002, 8'hA4));
        drain();

        // Trigger with post_count=1 finishes on the trigger cycle itself.
        trig_addr = 16'h1234;
        post_count = 5'd1;
        do_arm(1'b1);
        bus(16'h1234, 8'h5A, 1'b0, 1'b0);
        check("post1_state", 32'(state), 32'd3);
        check("post1_fill", 32'(fill), 32'd1);
        exp_q.push_back(ent(1'b0, 1'b0, 16'h1234, 8'h5A));
        drain();

        // Address window edges, then an inverted window.
        win_lo = 16'h0100;
        win_hi = 16'h01FF;
        do_arm(1'b0);
        bus(16'h00FF, 8'h01, 1'b0, 1'b0);
        bus(16'h0100, 8'h02, 1'b1, 1'b0);
        bus(16'h01FF, 8'h03, 1'b0, 1'b0);
        bus(16'h0200, 8'h04, 1'b1, 1'b0);
        check("win_fill", 32'(fill), 32'd2);
        check("win_cnt_sum", 32'(rd_cnt) + 32'(wr_cnt), 32'd2);
        win_lo = 16'h0200;
        win_hi = 16'h0100;
        bus(16'h0150, 8'h05, 1'b0, 1'b0);
        check("win_inv_fill", 32'(fill), 32'd2);
        check("win_inv_wr", 32'(wr_cnt), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_state", 32'(state), 32'd3);
        exp_q.push_back(ent(1'b0, 1'b1, 16'h0100, 8'h02));
        exp_q.push_back(ent(1'b0, 1'b0, 16'h01FF, 8'h03));
        drain();

        // Full FIFO with simultaneous push and pop.
        win_lo = 16'h0000;
        win_hi = 16'hFFFF;
        do_arm(1'b0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ent(1'b0, 1'b0, 16'h0300 + 16'(i), 8'h40 + 8'(i)));
            bus(16'h0300 + 16'(i), 8'h40 + 8'(i), 1'b0, 1'b0);
        end
        check("pp_full", 32'(fill), 32'd16);
        rd_ready = 1'b1;
        for (int i = 16; i < 24; i++) begin
            exp_q.push_back(ent(1'b0, 1'b0, 16'h0300 + 16'(i), 8'h40 + 8'(i)));
            bus(16'h0300 + 16'(i), 8'h40 + 8'(i), 1'b0, 1'b0);
            check("pp_fill", 32'(fill), 32'd16);
        end
        check("pp_ovf", 32'(overflow), 32'd0);
        drain();

        // arm with a qualified cycle mid-capture, then asynchronous reset.
        do_arm(1'b0);
        for (int i = 0; i < 3; i++) bus(16'h0400 + 16'(i), 8'(i), 1'b0, 1'b0);
        check("rearm_pre_fill", 32'(fill), 32'd3);
        bus_valid = 1'b1;
        bus_addr = 16'h0500;
        bus_r_w_n = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        bus_valid = 1'b0;
        check("rearm_fill", 32'(fill), 32'd0);
        check("rearm_state", 32'(state), 32'd2);
        check("rearm_wr_cnt", 32'(wr_cnt), 32'd0);
        bus(16'h0600, 8'h11, 1'b0, 1'b0);
        bus(16'h0601, 8'h12, 1'b1, 1'b1);
        check("rearm_post_fill", 32'(fill), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_entry", 32'(rd_entry), 32'd0);
        check("arst_cnts", 32'(rd_cnt) + 32'(wr_cnt) + 32'(fetch_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
